// File: rtl/lfu_pkg.sv
// Shared types and helpers for the LFU replacement block and its request front end.
package lfu_pkg;

    localparam int NUM_WAYS = 4;

    typedef logic [1:0] way_idx_t;

    function automatic logic [NUM_WAYS-1:0] idx_to_onehot(way_idx_t idx);
        logic [NUM_WAYS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lfu_req_gen_if.sv
// Valid/ready request channel from the request generator to the LFU block.
interface lfu_req_gen_if;
    import lfu_pkg::*;

    logic                req_valid;
    way_idx_t            req_idx;
    logic [NUM_WAYS-1:0] req_onehot;
    logic                req_ready;

    modport master (output req_valid, req_idx, req_onehot, input  req_ready);
    modport slave  (input  req_valid, req_idx, req_onehot, output req_ready);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one pushbutton; press pulses
// for one cycle after the stable level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            level_d <= level;
            // The edge that would bring cnt to DEBOUNCE_CYCLES flips the level instead.
            if (sync_p1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/lfu_req_gen.sv
// Turns debounced button presses into one-at-a-time LFU access requests through
// a pending-bit arbiter and a small FIFO.
module lfu_req_gen
    import lfu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WAYS-1:0]         btn_raw,
    lfu_req_gen_if.master               req,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int                PTR_W = $clog2(FIFO_DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_DEPTH);

    logic [NUM_WAYS-1:0] stable_unused;
    logic [NUM_WAYS-1:0] press;
    logic [NUM_WAYS-1:0] pending;
    logic [NUM_WAYS-1:0] pending_n;
    way_idx_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    way_idx_t            push_idx;
    logic                push;
    logic                pop;
    logic                collide;

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (stable_unused[i]),
            .press (press[i])
        );
    end

    always_comb begin
        push_idx = '0;
        // Descending scan so the lowest set pending bit wins.
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (pending[i]) push_idx = way_idx_t'(i);
        end
        pop     = req.req_valid && req.req_ready;
        push    = (|pending) && ((fifo_count < FULL) || pop);
        collide = |(press & pending);
        pending_n = pending;
        if (push) pending_n[push_idx] = 1'b0;
        pending_n = pending_n | press;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            pending <= pending_n;
            if (collide) overflow <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign req.req_valid  = (fifo_count != '0);
    assign req.req_idx    = req.req_valid ? mem[rd_ptr] : '0;
    assign req.req_onehot = req.req_valid ? idx_to_onehot(mem[rd_ptr]) : '0;

endmodule
